// File: rtl/pi_hsk_pkg.sv
// Shared definitions for the Pi 4-phase handshake receiver: FSM encoding
// and default parameter values.
package pi_hsk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hsk_state_t;

    localparam int DATA_W_DEF      = 8;
    localparam int DEPTH_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int TIMEOUT_DEF     = 1000000;

endpackage

// File: rtl/pi_hsk_fifo.sv
// Receive FIFO for the Pi handshake receiver: power-of-two depth,
// wrapping pointers, occupancy counter, head word zeroed while empty.
module pi_hsk_fifo
    import pi_hsk_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] fill
);

    localparam int AW     = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign valid   = (fill != '0);
    assign full    = (fill == FILL_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && valid;
    assign rd_data = valid ? mem[rd_ptr] : '0;

    // NOTE: storage has no reset; emptiness is tracked by fill and the
    // head word is masked to zero until something has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/pi_hsk_rx.sv
// Pi 4-phase handshake receiver: synchronises the request, acknowledges one
// word per request cycle into a FIFO, and flags acknowledges held too long.
module pi_hsk_rx
    import pi_hsk_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pi_hsk_raw,
    input  logic [DATA_W-1:0]          data,
    output logic                       fpga_hsk,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic [15:0]                rx_count,
    output logic                       timeout_err,
    input  logic                       err_clr
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    hsk_state_t             state;
    hsk_state_t             state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;
    logic [CNT_W-1:0]       ack_cnt;
    logic                   cnt_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pi_hsk_raw};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assignment first, so no path through the block leaves
    // state_next unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_s && !fifo_full) state_next = ACK;
            ACK:     if (!req_s)              state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // The acknowledge is a pure decode of the state register, so it is glitch-free.
    always_comb begin
        fpga_hsk = (state == ACK);
        push     = (state == IDLE) && req_s && !fifo_full;
    end

    assign pop = m_valid && m_ready;

    pi_hsk_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (data),
        .pop     (pop),
        .rd_data (m_data),
        .valid   (m_valid),
        .full    (fifo_full),
        .fill    (fill)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_count <= '0;
        end else if (push) begin
            rx_count <= rx_count + 16'd1;
        end
    end

    // Counter saturates at TIMEOUT so the error sets once per ACK episode.
    assign cnt_hit = (TIMEOUT != 0) && (state == ACK) && (ack_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || state != ACK) begin
            ack_cnt <= '0;
        end else if (TIMEOUT != 0 && ack_cnt != CNT_W'(TIMEOUT)) begin
            ack_cnt <= ack_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (cnt_hit) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

endmodule
